// File: rtl/poly_cmd_sequencer_if.sv
// Command, core-control and completion signals of the polynomial command sequencer.
// The slave modport is the sequencer's view, and the master modport is the
// surrounding environment (command source, core and completion sink).
interface poly_cmd_sequencer_if #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 12
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_opcode;
   logic             cmd_mode;
   logic             cmd_offset;
   logic [TAG_W-1:0] cmd_tag;
   logic             flush;
   logic [1:0]       opcode;
   logic             mode;
   logic             offset;
   logic             start;
   logic             finish;
   logic             busy;
   logic             done_valid;
   logic [TAG_W-1:0] done_tag;
   logic             done_err;
   logic [CNT_W-1:0] done_cycles;

   modport master (
      output cmd_valid, cmd_opcode, cmd_mode, cmd_offset, cmd_tag, flush, finish,
      input  cmd_ready, opcode, mode, offset, start, busy,
             done_valid, done_tag, done_err, done_cycles
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_mode, cmd_offset, cmd_tag, flush, finish,
      output cmd_ready, opcode, mode, offset, start, busy,
             done_valid, done_tag, done_err, done_cycles
   );
endinterface

// File: rtl/poly_cmd_sequencer.sv
// Command sequencer in front of the NTT/INTT/PWM core. It queues tagged commands,
// launches them one at a time with a start pulse, waits for finish or a timeout
// and reports the completion with tag, error flag and run-cycle count.
module poly_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int CNT_W   = 12,
   parameter int TIMEOUT = 4000
) (
   input logic                 clk,
   input logic                 rst,
   poly_cmd_sequencer_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENT_W = 4 + TAG_W;

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [ENT_W-1:0] fifo_q [DEPTH];
   logic [ENT_W-1:0] fifo_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [1:0]       opcode_q, opcode_d;
   logic             mode_q, mode_d, offset_q, offset_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             start_q, start_d, busy_q, busy_d;
   logic             done_valid_q, done_valid_d, done_err_q, done_err_d;
   logic [TAG_W-1:0] done_tag_q, done_tag_d;
   logic [CNT_W-1:0] done_cycles_q, done_cycles_d;
   logic             full, empty, push, pop;

   assign full          = (count_q == (PTR_W+1)'(DEPTH));
   assign empty         = (count_q == '0);
   assign bus.cmd_ready = !full && !bus.flush && !rst;
   assign push          = bus.cmd_valid && bus.cmd_ready;
   assign pop           = (state_q == IDLE) && !empty && !bus.flush;

   assign bus.opcode      = opcode_q;
   assign bus.mode        = mode_q;
   assign bus.offset      = offset_q;
   assign bus.start       = start_q;
   assign bus.busy        = busy_q;
   assign bus.done_valid  = done_valid_q;
   assign bus.done_tag    = done_tag_q;
   assign bus.done_err    = done_err_q;
   assign bus.done_cycles = done_cycles_q;

   // Queue bookkeeping: flush empties the queue and blocks that cycle's push and pop.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            fifo_d[wr_ptr_q] = {bus.cmd_opcode, bus.cmd_mode, bus.cmd_offset, bus.cmd_tag};
            wr_ptr_d         = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Command sequencing: pop and latch in IDLE, pulse start, count RUN cycles, report once.
   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      mode_d        = mode_q;
      offset_d      = offset_q;
      tag_d         = tag_q;
      cnt_d         = cnt_q;
      done_tag_d    = done_tag_q;
      done_err_d    = done_err_q;
      done_cycles_d = done_cycles_q;
      cnt_inc       = cnt_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (pop) begin
               {opcode_d, mode_d, offset_d, tag_d} = fifo_q[rd_ptr_q];
               cnt_d   = '0;
               state_d = LAUNCH;
            end
         end
         LAUNCH: state_d = RUN;
         RUN: begin
            cnt_d = cnt_inc;
            if (bus.finish) begin
               state_d       = DONE;
               done_err_d    = 1'b0;
               done_tag_d    = tag_q;
               done_cycles_d = cnt_inc;
            end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
               state_d       = DONE;
               done_err_d    = 1'b1;
               done_tag_d    = tag_q;
               done_cycles_d = cnt_inc;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      start_d      = (state_d == LAUNCH);
      busy_d       = (state_d != IDLE);
      done_valid_d = (state_d == DONE);
   end

   // Queue storage carries no reset; only the pointers and count define its contents.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   // State, pointers and registered outputs, all cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         opcode_q      <= '0;
         mode_q        <= 1'b0;
         offset_q      <= 1'b0;
         tag_q         <= '0;
         cnt_q         <= '0;
         start_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_valid_q  <= 1'b0;
         done_tag_q    <= '0;
         done_err_q    <= 1'b0;
         done_cycles_q <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         opcode_q      <= opcode_d;
         mode_q        <= mode_d;
         offset_q      <= offset_d;
         tag_q         <= tag_d;
         cnt_q         <= cnt_d;
         start_q       <= start_d;
         busy_q        <= busy_d;
         done_valid_q  <= done_valid_d;
         done_tag_q    <= done_tag_d;
         done_err_q    <= done_err_d;
         done_cycles_q <= done_cycles_d;
      end
   end
endmodule

// File: tb/tb_poly_cmd_sequencer.sv
// Bench for poly_cmd_sequencer: directed command scenarios plus a timestamp/queue
// model of the sequencer that is compared against the outputs on every cycle.
module tb_poly_cmd_sequencer;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;
   localparam int CNT_W   = 12;
   localparam int TIMEOUT = 4000;

   typedef struct {
      logic [1:0]       op;
      logic             md;
      logic             of;
      logic [TAG_W-1:0] tag;
   } cmd_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   cmd_t mq[$];
   cmd_t cur;
   cmd_t m_new;
   bit   job_on = 1'b0;
   bit   model_ok = 1'b0;
   bit   res_err = 1'b0;
   bit   m_idle, m_rdy;
   int   launch_at = -1;
   int   done_at = -1;
   int   res_cycles = 0;
   int   m_n;

   poly_cmd_sequencer_if #(.TAG_W(TAG_W), .CNT_W(CNT_W)) bus ();

   poly_cmd_sequencer #(
      .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one command and hold it until accepted; reports the cycle it was taken in.
   task automatic applyStimulus(input logic [1:0] op, input logic md, input logic of,
                                input logic [TAG_W-1:0] tg, output int acc_cyc);
      logic acc;
      int   budget;
      bus.cmd_valid  = 1'b1;
      bus.cmd_opcode = op;
      bus.cmd_mode   = md;
      bus.cmd_offset = of;
      bus.cmd_tag    = tg;
      budget         = 0;
      acc_cyc        = -1;
      do begin
         acc     = bus.cmd_ready;
         acc_cyc = cyc;
         tick();
         budget++;
      end while (!acc && budget < 20000);
      bus.cmd_valid = 1'b0;
      if (!acc) checkOutput("cmd_accept_timeout", 32'(acc), 32'(1));
   endtask

   task automatic waitStart(input string name, output int at);
      int n;
      n  = 0;
      at = -1;
      while (n < 100) begin
         @(negedge clk);
         if (bus.start === 1'b1) begin
            at = cyc;
            break;
         end
         n++;
      end
      if (at < 0) checkOutput(name, 32'(0), 32'(1));
   endtask

   task automatic waitDone(input string name, input int budget, output int at,
                           output logic [TAG_W-1:0] tg, output logic er, output logic [CNT_W-1:0] cy);
      int n;
      n  = 0;
      at = -1;
      tg = '0;
      er = 1'b0;
      cy = '0;
      while (n < budget) begin
         @(negedge clk);
         if (bus.done_valid === 1'b1) begin
            at = cyc;
            tg = bus.done_tag;
            er = bus.done_err;
            cy = bus.done_cycles;
            break;
         end
         n++;
      end
      if (at < 0) checkOutput(name, 32'(0), 32'(1));
   endtask

   // Reference model: a command queue plus launch/finish timestamps of the active job.
   always @(posedge clk) begin
      m_n = cyc;
      if (rst) begin
         mq.delete();
         job_on    = 1'b0;
         launch_at = -1;
         done_at   = -1;
         cur.op    = '0;
         cur.md    = 1'b0;
         cur.of    = 1'b0;
         cur.tag   = '0;
         model_ok  = 1'b1;
      end else begin
         m_idle = !job_on;
         m_rdy  = (mq.size() < DEPTH) && !bus.flush;
         if (job_on && done_at < 0 && m_n > launch_at) begin
            if (bus.finish) begin
               done_at    = m_n + 1;
               res_err    = 1'b0;
               res_cycles = m_n - launch_at;
            end else if (m_n - launch_at == TIMEOUT) begin
               done_at    = m_n + 1;
               res_err    = 1'b1;
               res_cycles = TIMEOUT;
            end
         end else if (job_on && m_n == done_at) begin
            job_on = 1'b0;
         end
         if (bus.flush) begin
            mq.delete();
         end else begin
            if (m_idle && mq.size() > 0) begin
               cur       = mq.pop_front();
               job_on    = 1'b1;
               launch_at = m_n + 1;
               done_at   = -1;
            end
            if (bus.cmd_valid && m_rdy) begin
               m_new.op  = bus.cmd_opcode;
               m_new.md  = bus.cmd_mode;
               m_new.of  = bus.cmd_offset;
               m_new.tag = bus.cmd_tag;
               mq.push_back(m_new);
            end
         end
      end
      cyc++;
   end

   // Every-cycle comparison of the DUT outputs against the model.
   always @(negedge clk) begin
      if (model_ok) begin
         checkOutput("mdl_start",  32'(bus.start),      32'(job_on && cyc == launch_at));
         checkOutput("mdl_busy",   32'(bus.busy),       32'(job_on));
         checkOutput("mdl_dvalid", 32'(bus.done_valid), 32'(job_on && cyc == done_at));
         checkOutput("mdl_opcode", 32'(bus.opcode),     32'(cur.op));
         checkOutput("mdl_mode",   32'(bus.mode),       32'(cur.md));
         checkOutput("mdl_offset", 32'(bus.offset),     32'(cur.of));
         checkOutput("mdl_ready",  32'(bus.cmd_ready),
                     32'(!rst && (mq.size() < DEPTH) && !bus.flush));
         if (job_on && cyc == done_at) begin
            checkOutput("mdl_dtag",    32'(bus.done_tag),    32'(cur.tag));
            checkOutput("mdl_derr",    32'(bus.done_err),    32'(res_err));
            checkOutput("mdl_dcycles", 32'(bus.done_cycles), 32'(res_cycles));
         end
      end
   end

   // Hard stop in case a scenario wedges.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      int               a, a0, a4, s, s2, d, f, n_ev;
      logic [TAG_W-1:0] tg;
      logic             er;
      logic [CNT_W-1:0] cy;
      a0 = 0;
      a4 = 0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_opcode = '0;
      bus.cmd_mode   = 1'b0;
      bus.cmd_offset = 1'b0;
      bus.cmd_tag    = '0;
      bus.flush      = 1'b0;
      bus.finish     = 1'b0;
      rst            = 1'b1;
      repeat (3) tick();

      // Reset state
      @(negedge clk);
      checkOutput("rst_start",   32'(bus.start),       32'(0));
      checkOutput("rst_busy",    32'(bus.busy),        32'(0));
      checkOutput("rst_dvalid",  32'(bus.done_valid),  32'(0));
      checkOutput("rst_opcode",  32'(bus.opcode),      32'(0));
      checkOutput("rst_dcycles", 32'(bus.done_cycles), 32'(0));
      checkOutput("rst_ready_hi_rst", 32'(bus.cmd_ready), 32'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready_after", 32'(bus.cmd_ready), 32'(1));
      tick();

      // 1: single command, finish 30 cycles after start
      applyStimulus(2'd2, 1'b1, 1'b0, 4'd5, a);
      waitStart("t1_start_seen", s);
      checkOutput("t1_start_latency", 32'(s - a), 32'(2));
      checkOutput("t1_opcode", 32'(bus.opcode), 32'(2));
      checkOutput("t1_mode",   32'(bus.mode),   32'(1));
      checkOutput("t1_offset", 32'(bus.offset), 32'(0));
      repeat (30) @(posedge clk);
      #1 bus.finish = 1'b1;
      f = cyc;
      tick();
      bus.finish = 1'b0;
      waitDone("t1_done_seen", 50, d, tg, er, cy);
      checkOutput("t1_done_latency", 32'(d - f), 32'(1));
      checkOutput("t1_tag",    32'(tg), 32'(5));
      checkOutput("t1_err",    32'(er), 32'(0));
      checkOutput("t1_cycles", 32'(cy), 32'(30));
      checkOutput("t1_opcode_held", 32'(bus.opcode), 32'(2));
      repeat (3) tick();

      // 2: five back-to-back commands into a 4-deep queue
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'(i), 1'(i % 2), 1'((i / 2) % 2), TAG_W'(i), a);
         if (i == 0) a0 = a;
         if (i == 4) a4 = a;
      end
      checkOutput("t2_no_stall",   32'(a4 - a0), 32'(4));
      checkOutput("t2_ready_full", 32'(bus.cmd_ready), 32'(0));
      bus.finish = 1'b1;
      tick();
      bus.finish = 1'b0;
      waitDone("t2_done0_seen", 50, d, tg, er, cy);
      checkOutput("t2_tag0",    32'(tg), 32'(0));
      checkOutput("t2_cycles0", 32'(cy), 32'(3));
      for (int i = 1; i < 5; i++) begin
         waitStart("t2_start_seen", s);
         repeat (2 + i) @(posedge clk);
         #1 bus.finish = 1'b1;
         tick();
         bus.finish = 1'b0;
         waitDone("t2_done_seen", 50, d, tg, er, cy);
         checkOutput("t2_tag",    32'(tg), 32'(i));
         checkOutput("t2_err",    32'(er), 32'(0));
         checkOutput("t2_cycles", 32'(cy), 32'(2 + i));
      end
      repeat (3) tick();

      // 3: timeout, then the next queued command launches
      applyStimulus(2'd1, 1'b0, 1'b1, 4'd9, a);
      applyStimulus(2'd3, 1'b1, 1'b1, 4'd10, a);
      waitStart("t3_start_seen", s);
      waitDone("t3_done_seen", TIMEOUT + 50, d, tg, er, cy);
      checkOutput("t3_timeout_latency", 32'(d - s), 32'(4001));
      checkOutput("t3_tag",    32'(tg), 32'(9));
      checkOutput("t3_err",    32'(er), 32'(1));
      checkOutput("t3_cycles", 32'(cy), 32'(4000));
      waitStart("t3_next_start_seen", s2);
      checkOutput("t3_relaunch_gap", 32'(s2 - d), 32'(2));
      checkOutput("t3_next_opcode",  32'(bus.opcode), 32'(3));
      @(posedge clk);
      #1 bus.finish = 1'b1;
      tick();
      bus.finish = 1'b0;
      waitDone("t3_next_done_seen", 50, d, tg, er, cy);
      checkOutput("t3_next_tag",    32'(tg), 32'(10));
      checkOutput("t3_next_cycles", 32'(cy), 32'(1));
      repeat (3) tick();

      // 4: finish while IDLE and during LAUNCH is ignored
      bus.finish = 1'b1;
      tick();
      bus.finish = 1'b0;
      @(negedge clk);
      checkOutput("t4_idle_busy",   32'(bus.busy),       32'(0));
      checkOutput("t4_idle_dvalid", 32'(bus.done_valid), 32'(0));
      tick();
      applyStimulus(2'd0, 1'b0, 1'b0, 4'd3, a);
      waitStart("t4_start_seen", s);
      bus.finish = 1'b1;
      @(posedge clk);
      #1 bus.finish = 1'b0;
      @(negedge clk);
      checkOutput("t4_launch_busy",   32'(bus.busy),       32'(1));
      checkOutput("t4_launch_dvalid", 32'(bus.done_valid), 32'(0));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 bus.finish = 1'b1;
      tick();
      bus.finish = 1'b0;
      waitDone("t4_done_seen", 50, d, tg, er, cy);
      checkOutput("t4_tag",    32'(tg), 32'(3));
      checkOutput("t4_cycles", 32'(cy), 32'(3));
      repeat (3) tick();

      // 5: flush discards queued commands and the push offered alongside it
      applyStimulus(2'd1, 1'b1, 1'b1, 4'd1, a);
      waitStart("t5_start_seen", s);
      applyStimulus(2'd2, 1'b0, 1'b0, 4'd2, a);
      applyStimulus(2'd3, 1'b0, 1'b1, 4'd3, a);
      applyStimulus(2'd0, 1'b1, 1'b0, 4'd4, a);
      bus.flush      = 1'b1;
      bus.cmd_valid  = 1'b1;
      bus.cmd_tag    = 4'd7;
      bus.cmd_opcode = 2'd2;
      @(negedge clk);
      checkOutput("t5_flush_ready", 32'(bus.cmd_ready), 32'(0));
      tick();
      bus.flush     = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.finish    = 1'b1;
      tick();
      bus.finish = 1'b0;
      waitDone("t5_done_seen", 50, d, tg, er, cy);
      checkOutput("t5_tag", 32'(tg), 32'(1));
      checkOutput("t5_err", 32'(er), 32'(0));
      n_ev = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.start === 1'b1) n_ev++;
      end
      checkOutput("t5_no_launch",  32'(n_ev), 32'(0));
      checkOutput("t5_idle_busy",  32'(bus.busy), 32'(0));
      checkOutput("t5_ready_empty", 32'(bus.cmd_ready), 32'(1));
      tick();

      // 6: reset in RUN with two commands queued
      applyStimulus(2'd2, 1'b0, 1'b1, 4'd6, a);
      waitStart("t6_start_seen", s);
      applyStimulus(2'd1, 1'b1, 1'b0, 4'd11, a);
      applyStimulus(2'd3, 1'b1, 1'b1, 4'd12, a);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t6_start",   32'(bus.start),       32'(0));
      checkOutput("t6_busy",    32'(bus.busy),        32'(0));
      checkOutput("t6_dvalid",  32'(bus.done_valid),  32'(0));
      checkOutput("t6_opcode",  32'(bus.opcode),      32'(0));
      checkOutput("t6_offset",  32'(bus.offset),      32'(0));
      checkOutput("t6_dtag",    32'(bus.done_tag),    32'(0));
      checkOutput("t6_dcycles", 32'(bus.done_cycles), 32'(0));
      checkOutput("t6_ready",   32'(bus.cmd_ready),   32'(1));
      n_ev = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.start === 1'b1 || bus.done_valid === 1'b1) n_ev++;
      end
      checkOutput("t6_quiet_after_rst", 32'(n_ev), 32'(0));
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
